// File: rtl/tage_update_if.sv
// Request / response / table-strobe bundle for the TAGE tagged-table update controller.
// The stat_* counters exist only when TAGE_UPD_STATS_EN is defined.
interface tage_update_if #(
  parameter int IL      = 10,
  parameter int TAG_LEN = 8,
  parameter int UL      = 2,
  parameter int CL      = 3
);
  logic               req_valid;
  logic               req_ready;
  logic [IL-1:0]      req_index;
  logic [TAG_LEN-1:0] req_tag;
  logic               req_taken;
  logic               req_alt_pred;
  logic               resp_valid;
  logic               resp_hit;
  logic               resp_mispred;
  logic               tbl_rd;
  logic               tbl_wr;
  logic [IL-1:0]      tbl_index;
  logic [TAG_LEN-1:0] tbl_wdata_tag;
  logic [TAG_LEN-1:0] tbl_rdata_tag;
  logic [UL-1:0]      tbl_rdata_u;
  logic [CL-1:0]      tbl_rdata_c;
  logic               tbl_inc_c;
  logic               tbl_dec_c;
  logic               tbl_inc_u;
  logic               tbl_dec_u;
  logic               tbl_alloc;
  logic               tbl_update_en;
`ifdef TAGE_UPD_STATS_EN
  logic [15:0]        stat_alloc;
  logic [15:0]        stat_alloc_fail;
  logic [15:0]        stat_mispred;

  modport slave (
    input  req_valid, req_index, req_tag, req_taken, req_alt_pred,
           tbl_rdata_tag, tbl_rdata_u, tbl_rdata_c,
    output req_ready, resp_valid, resp_hit, resp_mispred,
           tbl_rd, tbl_wr, tbl_index, tbl_wdata_tag,
           tbl_inc_c, tbl_dec_c, tbl_inc_u, tbl_dec_u, tbl_alloc, tbl_update_en,
           stat_alloc, stat_alloc_fail, stat_mispred
  );
  modport master (
    output req_valid, req_index, req_tag, req_taken, req_alt_pred,
           tbl_rdata_tag, tbl_rdata_u, tbl_rdata_c,
    input  req_ready, resp_valid, resp_hit, resp_mispred,
           tbl_rd, tbl_wr, tbl_index, tbl_wdata_tag,
           tbl_inc_c, tbl_dec_c, tbl_inc_u, tbl_dec_u, tbl_alloc, tbl_update_en,
           stat_alloc, stat_alloc_fail, stat_mispred
  );
`else
  modport slave (
    input  req_valid, req_index, req_tag, req_taken, req_alt_pred,
           tbl_rdata_tag, tbl_rdata_u, tbl_rdata_c,
    output req_ready, resp_valid, resp_hit, resp_mispred,
           tbl_rd, tbl_wr, tbl_index, tbl_wdata_tag,
           tbl_inc_c, tbl_dec_c, tbl_inc_u, tbl_dec_u, tbl_alloc, tbl_update_en
  );
  modport master (
    output req_valid, req_index, req_tag, req_taken, req_alt_pred,
           tbl_rdata_tag, tbl_rdata_u, tbl_rdata_c,
    input  req_ready, resp_valid, resp_hit, resp_mispred,
           tbl_rd, tbl_wr, tbl_index, tbl_wdata_tag,
           tbl_inc_c, tbl_dec_c, tbl_inc_u, tbl_dec_u, tbl_alloc, tbl_update_en
  );
`endif
endinterface

// File: rtl/tage_update_ctrl.sv
// Update/allocation controller for one TAGE tagged table: IDLE->READ->EVAL->UPD, one request in flight.
// Optional statistics counters are enabled by defining TAGE_UPD_STATS_EN.
module tage_update_ctrl #(
  parameter int IL      = 10,
  parameter int TAG_LEN = 8,
  parameter int UL      = 2,
  parameter int CL      = 3
) (
  input logic         Clk,
  input logic         reset,
  tage_update_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, EVAL, UPD} state_t;

  state_t             state, state_nxt;
  logic [IL-1:0]      index_q;
  logic [TAG_LEN-1:0] tag_q;
  logic               taken_q, alt_q;
  logic               hit_q, mispred_q, fail_q;
  logic               inc_c_q, dec_c_q, inc_u_q, dec_u_q, alloc_q, upd_q;
  logic               accept;
  logic               hit, cmsb, pred, mispred, u_zero;

  assign accept = bus.req_valid && (state == IDLE);

  always_ff @(posedge Clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = EVAL;
      EVAL:    state_nxt = UPD;
      default: state_nxt = IDLE;
    endcase
  end

  // Index and tag are visible on the table port, so they are cleared by reset.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      index_q <= '0;
      tag_q   <= '0;
    end else if (accept) begin
      index_q <= bus.req_index;
      tag_q   <= bus.req_tag;
    end
  end

  always_ff @(posedge Clk) begin
    if (accept) begin
      taken_q <= bus.req_taken;
      alt_q   <= bus.req_alt_pred;
    end
  end

  // Read data is only valid during EVAL, so every decision is captured here.
  always_comb begin
    hit     = (bus.tbl_rdata_tag == tag_q);
    cmsb    = bus.tbl_rdata_c[CL-1];
    pred    = hit ? cmsb : alt_q;
    mispred = (pred != taken_q);
    u_zero  = (bus.tbl_rdata_u == '0);
  end

  always_ff @(posedge Clk) begin
    if (state == EVAL) begin
      hit_q     <= hit;
      mispred_q <= mispred;
      fail_q    <= !hit && mispred && !u_zero;
      inc_c_q   <= hit && taken_q;
      dec_c_q   <= hit && !taken_q;
      inc_u_q   <= hit && (cmsb != alt_q) && (cmsb == taken_q);
      dec_u_q   <= hit ? ((cmsb != alt_q) && (cmsb != taken_q)) : mispred;
      alloc_q   <= !hit && mispred && u_zero;
      upd_q     <= hit || mispred;
    end
  end

  always_comb begin
    bus.req_ready     = (state == IDLE);
    bus.tbl_rd        = (state == READ);
    bus.tbl_index     = index_q;
    bus.tbl_wdata_tag = tag_q;
    bus.resp_valid    = 1'b0;
    bus.resp_hit      = 1'b0;
    bus.resp_mispred  = 1'b0;
    bus.tbl_inc_c     = 1'b0;
    bus.tbl_dec_c     = 1'b0;
    bus.tbl_inc_u     = 1'b0;
    bus.tbl_dec_u     = 1'b0;
    bus.tbl_alloc     = 1'b0;
    bus.tbl_update_en = 1'b0;
    if (state == UPD) begin
      bus.resp_valid    = 1'b1;
      bus.resp_hit      = hit_q;
      bus.resp_mispred  = mispred_q;
      bus.tbl_inc_c     = inc_c_q;
      bus.tbl_dec_c     = dec_c_q;
      bus.tbl_inc_u     = inc_u_q;
      bus.tbl_dec_u     = dec_u_q;
      bus.tbl_alloc     = alloc_q;
      bus.tbl_update_en = upd_q;
    end
    bus.tbl_wr = bus.tbl_update_en;
  end

`ifdef TAGE_UPD_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  logic [15:0] stat_alloc_q, stat_fail_q, stat_mispred_q;

  always_ff @(posedge Clk) begin
    if (!reset) begin
      stat_alloc_q   <= '0;
      stat_fail_q    <= '0;
      stat_mispred_q <= '0;
    end else if (state == UPD) begin
      stat_alloc_q   <= sat_inc(stat_alloc_q, alloc_q);
      stat_fail_q    <= sat_inc(stat_fail_q, fail_q);
      stat_mispred_q <= sat_inc(stat_mispred_q, mispred_q);
    end
  end

  assign bus.stat_alloc      = stat_alloc_q;
  assign bus.stat_alloc_fail = stat_fail_q;
  assign bus.stat_mispred    = stat_mispred_q;
`endif
endmodule

// File: tb/tb_tage_update_ctrl.sv
// Directed + randomized bench for tage_update_ctrl with a behavioural tagged-table model.
module tb_tage_update_ctrl;
  localparam int IL = 10, TAG_LEN = 8, UL = 2, CL = 3;

  logic Clk = 1'b0;
  logic reset = 1'b0;
  always #5 Clk = ~Clk;

  tage_update_if #(.IL(IL), .TAG_LEN(TAG_LEN), .UL(UL), .CL(CL)) bus ();

  tage_update_ctrl #(.IL(IL), .TAG_LEN(TAG_LEN), .UL(UL), .CL(CL)) dut (
    .Clk  (Clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Table model: registered read, saturating counters, tag write on alloc, poke port for setup.
  bit [TAG_LEN-1:0] mtag [1024];
  bit [UL-1:0]      mu   [1024];
  bit [CL-1:0]      mc   [1024];
  logic             poke_en = 1'b0;
  logic [IL-1:0]    poke_idx = '0;
  logic [TAG_LEN-1:0] poke_tag = '0;
  logic [UL-1:0]    poke_u = '0;
  logic [CL-1:0]    poke_c = '0;

  always @(posedge Clk) begin
    if (bus.tbl_rd) begin
      bus.tbl_rdata_tag <= mtag[bus.tbl_index];
      bus.tbl_rdata_u   <= mu[bus.tbl_index];
      bus.tbl_rdata_c   <= mc[bus.tbl_index];
    end else begin
      bus.tbl_rdata_tag <= '0;
      bus.tbl_rdata_u   <= '0;
      bus.tbl_rdata_c   <= '0;
    end
    if (bus.tbl_update_en) begin
      if (bus.tbl_inc_c && mc[bus.tbl_index] != 3'd7) mc[bus.tbl_index] <= mc[bus.tbl_index] + 3'd1;
      if (bus.tbl_dec_c && mc[bus.tbl_index] != 3'd0) mc[bus.tbl_index] <= mc[bus.tbl_index] - 3'd1;
      if (bus.tbl_inc_u && mu[bus.tbl_index] != 2'd3) mu[bus.tbl_index] <= mu[bus.tbl_index] + 2'd1;
      if (bus.tbl_dec_u && mu[bus.tbl_index] != 2'd0) mu[bus.tbl_index] <= mu[bus.tbl_index] - 2'd1;
      if (bus.tbl_alloc) mtag[bus.tbl_index] <= bus.tbl_wdata_tag;
    end
    if (poke_en) begin
      mtag[poke_idx] <= poke_tag;
      mu[poke_idx]   <= poke_u;
      mc[poke_idx]   <= poke_c;
    end
  end

  int total = 0, passed = 0, failed = 0;
  int exp_alloc = 0, exp_fail = 0, exp_misp = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic set_entry(input int idx, input int tag, input int u, input int c);
    poke_en = 1'b1; poke_idx = IL'(idx); poke_tag = TAG_LEN'(tag); poke_u = UL'(u); poke_c = CL'(c);
    tick();
    poke_en = 1'b0;
  endtask

  function automatic logic [5:0] strobes();
    return {bus.tbl_inc_c, bus.tbl_dec_c, bus.tbl_inc_u, bus.tbl_dec_u, bus.tbl_alloc, bus.tbl_update_en};
  endfunction

  task automatic check_stats(input string where);
`ifdef TAGE_UPD_STATS_EN
    check({where, "_stat_alloc"}, 32'(bus.stat_alloc), 32'(exp_alloc));
    check({where, "_stat_alloc_fail"}, 32'(bus.stat_alloc_fail), 32'(exp_fail));
    check({where, "_stat_mispred"}, 32'(bus.stat_mispred), 32'(exp_misp));
`endif
  endtask

  // One full request; expectations come straight from the TAGE update rules on the entry as it stands.
  task automatic do_req(input string name, input int idx, input int tag, input bit taken, input bit alt);
    bit hit, prd, mis, cm, ez, e_inc_c, e_dec_c, e_inc_u, e_dec_u, e_alloc, e_upd;
    int waited;
    hit = (int'(mtag[idx]) == tag);
    cm  = mc[idx][CL-1];
    ez  = (mu[idx] == 0);
    prd = hit ? cm : alt;
    mis = (prd != taken);
    e_inc_c = 0; e_dec_c = 0; e_inc_u = 0; e_dec_u = 0; e_alloc = 0;
    if (hit) begin
      if (taken) e_inc_c = 1; else e_dec_c = 1;
      if (cm != alt) begin
        if (cm == taken) e_inc_u = 1; else e_dec_u = 1;
      end
    end else if (mis) begin
      e_dec_u = 1;
      e_alloc = ez;
    end
    e_upd = hit || mis;

    waited = 0;
    while (!bus.req_ready && waited < 8) begin tick(); waited++; end
    check({name, "_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_index = IL'(idx); bus.req_tag = TAG_LEN'(tag);
    bus.req_taken = taken; bus.req_alt_pred = alt;
    tick();
    bus.req_valid = 1'b0;
    check({name, "_read"}, {bus.tbl_rd, bus.resp_valid, bus.req_ready, 22'(bus.tbl_index)},
          {1'b1, 1'b0, 1'b0, 22'(idx)});
    tick();
    check({name, "_eval"}, {bus.tbl_rd, bus.resp_valid, bus.tbl_update_en}, 3'b000);
    tick();
    check({name, "_resp"}, {bus.resp_valid, bus.resp_hit, bus.resp_mispred}, {1'b1, hit, mis});
    check({name, "_strobes"}, 32'(strobes()), 32'({e_inc_c, e_dec_c, e_inc_u, e_dec_u, e_alloc, e_upd}));
    check({name, "_wr"}, {bus.tbl_wr, 22'(bus.tbl_index)}, {e_upd, 22'(idx)});
    if (e_alloc) check({name, "_wdata_tag"}, 32'(bus.tbl_wdata_tag), 32'(tag));
    tick();
    check({name, "_done"}, {bus.resp_valid, bus.tbl_update_en, bus.req_ready}, 3'b001);
    exp_alloc += int'(e_alloc);
    exp_fail  += int'(!hit && mis && !ez);
    exp_misp  += int'(mis);
    check_stats(name);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_index = '0; bus.req_tag = '0;
    bus.req_taken = 1'b0; bus.req_alt_pred = 1'b0;
    @(negedge Clk);
    tick(); tick();
    check("reset_outputs",
          {bus.req_ready, bus.tbl_rd, bus.resp_valid, strobes(), bus.tbl_wr},
          {1'b1, 1'b0, 1'b0, 6'b0, 1'b0});
    check("reset_index_tag", {22'(bus.tbl_index), 8'(bus.tbl_wdata_tag)}, 30'd0);
    check_stats("reset");
    reset = 1'b1;

    // Reset asserted mid-READ drops the request.
    set_entry(5, 8'h11, 0, 0);
    bus.req_valid = 1'b1; bus.req_index = 10'd5; bus.req_tag = 8'h22;
    bus.req_taken = 1'b1; bus.req_alt_pred = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    check("t1_in_read", 32'(bus.tbl_rd), 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t1_reset_quiet", {bus.resp_valid, strobes(), bus.req_ready}, {1'b0, 6'b0, 1'b1});
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_after_release", {bus.resp_valid, bus.tbl_update_en, bus.req_ready}, 3'b001);
    end
    check("t1_entry_untouched", {mtag[5], 3'(mc[5]), 2'(mu[5])}, {8'h11, 3'd0, 2'd0});

    // Hit, correct, provider disagrees with alt.
    set_entry(9, 8'h5A, 0, 3'b100);
    do_req("t2", 9, 8'h5A, 1'b1, 1'b0);
    check("t2_entry", {3'(mc[9]), 2'(mu[9])}, {3'd5, 2'd1});

    // Hit, mispredict, provider disagrees with alt.
    set_entry(9, 8'h5A, 1, 3'b111);
    do_req("t3", 9, 8'h5A, 1'b0, 1'b0);
    check("t3_entry", {3'(mc[9]), 2'(mu[9])}, {3'd6, 2'd0});

    // Miss with u==0: allocate.
    set_entry(12, 8'h5A, 0, 3'b010);
    do_req("t4", 12, 8'h33, 1'b1, 1'b0);
    check("t4_entry", {mtag[12], 3'(mc[12]), 2'(mu[12])}, {8'h33, 3'b010, 2'd0});

    // Miss with u!=0: age only.
    set_entry(12, 8'h5A, 2, 3'b010);
    do_req("t5", 12, 8'h33, 1'b1, 1'b0);
    check("t5_entry", {mtag[12], 3'(mc[12]), 2'(mu[12])}, {8'h5A, 3'b010, 2'd1});

    // Back-to-back held request, miss & correct.
    set_entry(3, 8'h5A, 1, 3'b011);
    bus.req_valid = 1'b1; bus.req_index = 10'd3; bus.req_tag = 8'h33;
    bus.req_taken = 1'b1; bus.req_alt_pred = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      check("t6_accept", 32'(bus.req_valid & bus.req_ready), 32'((cyc % 4) == 0));
      check("t6_resp_upd", {bus.resp_valid, bus.tbl_update_en, bus.tbl_wr}, {((cyc % 4) == 3), 2'b00});
      tick();
    end
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t6_entry", {mtag[3], 3'(mc[3]), 2'(mu[3])}, {8'h5A, 3'b011, 2'd1});
    check_stats("t6");

    // Randomized requests over a small set of entries.
    for (int n = 0; n < 40; n++) begin
      int idx, tag;
      idx = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        set_entry(idx, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
      tag = ($urandom_range(0, 1) == 1) ? int'(mtag[idx]) : int'($urandom_range(0, 255));
      do_req("rnd", idx, tag, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
